// File: rtl/tx_stream_arbiter_if.sv
// AXI-stream bundle shared by NUM_SRC requesters and the single TX output.
// The arbiter uses the slave view; the environment driving the sources and
// the downstream ready uses the master view.
interface tx_stream_arbiter_if #(
  parameter int unsigned NUM_SRC = 2,
  parameter int unsigned DATA_W  = 256
);
  logic [NUM_SRC*DATA_W-1:0] s_tdata;
  logic [NUM_SRC-1:0]        s_tvalid;
  logic [NUM_SRC-1:0]        s_tlast;
  logic [NUM_SRC-1:0]        s_tready;
  logic [DATA_W-1:0]         m_tdata;
  logic                      m_tvalid;
  logic                      m_tlast;
  logic                      m_tready;

  modport slave (
    input  s_tdata, s_tvalid, s_tlast, m_tready,
    output s_tready, m_tdata, m_tvalid, m_tlast
  );

  modport master (
    output s_tdata, s_tvalid, s_tlast, m_tready,
    input  s_tready, m_tdata, m_tvalid, m_tlast
  );
endinterface

// File: rtl/tx_stream_arbiter.sv
// Packet-granular round-robin arbiter in front of the TX MAC.
// A grant is held from the first beat until the tlast handshake, so beats of
// different sources never interleave. One bubble cycle per packet is spent
// in IDLE making the selection. Per-source completed-packet counters wrap.
module tx_stream_arbiter #(
  parameter int unsigned NUM_SRC = 2,
  parameter int unsigned DATA_W  = 256,
  parameter int unsigned SRC_W   = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_SRC-1:0]     i_src_enable,
  tx_stream_arbiter_if.slave     bus,
  output logic                   o_busy,
  output logic [SRC_W-1:0]       o_grant_id,
  output logic [NUM_SRC*32-1:0]  o_pkt_count
);

  typedef enum logic {
    S_IDLE,
    S_BUSY
  } state_t;

  state_t                   r_state;
  state_t                   w_next_state;
  logic [SRC_W-1:0]         r_grant_id;
  logic [SRC_W-1:0]         r_last_grant;
  logic [NUM_SRC-1:0][31:0] r_pkt_count;

  logic [NUM_SRC-1:0]       w_req;
  logic                     w_found;
  logic [SRC_W-1:0]         w_sel;
  int unsigned              w_idx;
  logic                     w_g_valid;
  logic                     w_g_last;
  logic                     w_xfer_last;
  logic [DATA_W-1:0]        w_m_tdata;
  logic                     w_m_tvalid;
  logic                     w_m_tlast;
  logic [NUM_SRC-1:0]       w_s_tready;

  assign w_req       = bus.s_tvalid & i_src_enable;
  assign w_g_valid   = bus.s_tvalid[r_grant_id];
  assign w_g_last    = bus.s_tlast[r_grant_id];
  assign w_xfer_last = (r_state == S_BUSY) && w_g_valid && bus.m_tready && w_g_last;

  // Round-robin pick: first requester after the most recent grant, wrapping.
  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    w_idx   = 0;
    for (int unsigned k = 1; k <= NUM_SRC; k++) begin
      w_idx = (32'(r_last_grant) + k) % NUM_SRC;
      if (!w_found && w_req[w_idx]) begin
        w_found = 1'b1;
        w_sel   = SRC_W'(w_idx);
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state and zero-latency datapath mux from the granted source.
  always_comb begin
    w_next_state = r_state;
    w_m_tdata    = '0;
    w_m_tvalid   = 1'b0;
    w_m_tlast    = 1'b0;
    w_s_tready   = '0;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_next_state = S_BUSY;
        end
      end
      S_BUSY: begin
        w_m_tdata              = bus.s_tdata[r_grant_id*DATA_W +: DATA_W];
        w_m_tvalid             = w_g_valid;
        w_m_tlast              = w_g_last;
        w_s_tready[r_grant_id] = bus.m_tready;
        if (w_xfer_last) begin
          w_next_state = S_IDLE;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Grant bookkeeping and per-source packet counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_grant_id   <= '0;
      r_last_grant <= SRC_W'(NUM_SRC - 1);
      r_pkt_count  <= '0;
    end else begin
      if (r_state == S_IDLE && w_found) begin
        r_grant_id <= w_sel;
      end
      if (w_xfer_last) begin
        r_pkt_count[r_grant_id] <= r_pkt_count[r_grant_id] + 32'd1;
        r_last_grant            <= r_grant_id;
      end
    end
  end

  assign bus.m_tdata  = w_m_tdata;
  assign bus.m_tvalid = w_m_tvalid;
  assign bus.m_tlast  = w_m_tlast;
  assign bus.s_tready = w_s_tready;
  assign o_busy       = (r_state == S_BUSY);
  assign o_grant_id   = r_grant_id;
  assign o_pkt_count  = r_pkt_count;

endmodule

// File: tb/tb_tx_stream_arbiter.sv
// Self-checking bench for tx_stream_arbiter: directed scenarios plus a long
// randomized run, all compared every cycle against a behavioural model.
module tb_tx_stream_arbiter;
  localparam int unsigned NUM_SRC = 2;
  localparam int unsigned DATA_W  = 256;
  localparam int unsigned SRC_W   = 3;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NUM_SRC-1:0]    src_enable;
  logic                  busy;
  logic [SRC_W-1:0]      grant_id;
  logic [NUM_SRC*32-1:0] pkt_count;

  always #5 clk = ~clk;

  tx_stream_arbiter_if #(.NUM_SRC(NUM_SRC), .DATA_W(DATA_W)) bus ();

  tx_stream_arbiter #(.NUM_SRC(NUM_SRC), .DATA_W(DATA_W), .SRC_W(SRC_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_src_enable (src_enable),
    .bus          (bus),
    .o_busy       (busy),
    .o_grant_id   (grant_id),
    .o_pkt_count  (pkt_count)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [DATA_W-1:0] obs,
                       input logic [DATA_W-1:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Behavioural model: who holds the grant, who was served last, counts.
  bit          md_busy;
  int          md_gnt;
  int          md_last;
  logic [31:0] md_cnt [NUM_SRC];

  // Source generators: packets left, beats left in current packet, next data.
  int                g_left [NUM_SRC];
  int                g_rem  [NUM_SRC];
  logic [DATA_W-1:0] g_dat  [NUM_SRC];
  int                g_lo = 1, g_hi = 4, g_vpct = 100;
  int                rdy_mode = 0, rdy_pct = 100;
  int                cyc = 0;

  int                gnt_log [$];
  logic [DATA_W-1:0] dat_log [$];
  bit                last_log[$];

  function automatic void model_reset();
    md_busy = 1'b0;
    md_gnt  = 0;
    md_last = NUM_SRC - 1;
    for (int i = 0; i < NUM_SRC; i++) begin
      md_cnt[i] = '0;
      g_rem[i]  = 0;
    end
  endfunction

  function automatic void clear_logs();
    gnt_log.delete();
    dat_log.delete();
    last_log.delete();
  endfunction

  task automatic drive();
    for (int i = 0; i < NUM_SRC; i++) begin
      if (g_rem[i] == 0 && g_left[i] > 0) begin
        g_rem[i] = $urandom_range(g_hi, g_lo);
        g_left[i]--;
      end
      bus.s_tvalid[i] = (g_rem[i] > 0) && ($urandom_range(99, 0) < g_vpct);
      bus.s_tlast[i]  = (g_rem[i] == 1);
      bus.s_tdata[i*DATA_W +: DATA_W] = g_dat[i];
    end
    bus.m_tready = (rdy_mode == 1) ? (cyc % 2 == 1) : ($urandom_range(99, 0) < rdy_pct);
  endtask

  // Compare outputs at negedge, then advance the model to the next edge.
  task automatic step();
    logic [NUM_SRC-1:0]    e_rdy;
    logic [NUM_SRC*32-1:0] e_cnt;
    logic                  e_v;
    bit                    picked;
    int                    c;
    @(negedge clk);
    e_rdy = '0;
    e_v   = md_busy ? bus.s_tvalid[md_gnt] : 1'b0;
    if (md_busy) e_rdy[md_gnt] = bus.m_tready;
    for (int i = 0; i < NUM_SRC; i++) e_cnt[i*32 +: 32] = md_cnt[i];
    check("m_tvalid", bus.m_tvalid, e_v);
    check("m_tlast", bus.m_tlast, md_busy ? bus.s_tlast[md_gnt] : 1'b0);
    if (!md_busy) check("m_tdata_idle", bus.m_tdata, '0);
    else if (e_v) check("m_tdata", bus.m_tdata, bus.s_tdata[md_gnt*DATA_W +: DATA_W]);
    check("s_tready", bus.s_tready, e_rdy);
    check("busy", busy, md_busy);
    check("grant_id", grant_id, md_gnt);
    check("pkt_count", pkt_count, e_cnt);

    if (rst) begin
      model_reset();
    end else if (!md_busy) begin
      picked = 0;
      for (int off = 1; off <= NUM_SRC; off++) begin
        c = (md_last + off) % NUM_SRC;
        if (!picked && bus.s_tvalid[c] && src_enable[c]) begin
          picked  = 1;
          md_busy = 1'b1;
          md_gnt  = c;
          gnt_log.push_back(c);
        end
      end
    end else if (bus.s_tvalid[md_gnt] && bus.m_tready) begin
      dat_log.push_back(g_dat[md_gnt]);
      last_log.push_back(bus.s_tlast[md_gnt]);
      g_rem[md_gnt]--;
      g_dat[md_gnt] = g_dat[md_gnt] + 1;
      if (bus.s_tlast[md_gnt]) begin
        md_cnt[md_gnt] = md_cnt[md_gnt] + 32'd1;
        md_last = md_gnt;
        md_busy = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run(input int n);
    repeat (n) begin
      drive();
      step();
    end
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    run(1);
    rst = 1'b0;
  endtask

  logic [NUM_SRC*32-1:0] pk;
  logic [DATA_W-1:0]     exp_seq [8];

  initial begin
    rst          = 1'b1;
    src_enable   = '1;
    bus.s_tdata  = '0;
    bus.s_tvalid = '0;
    bus.s_tlast  = '0;
    bus.m_tready = 1'b1;
    for (int i = 0; i < NUM_SRC; i++) begin
      g_left[i] = 0;
      g_dat[i]  = '0;
    end
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Idle after reset with downstream ready.
    run(2);
    check("rst_pkt_count", pkt_count, '0);

    // Source 1 alone, one 3-beat packet A1,A2,A3.
    clear_logs();
    g_lo = 3; g_hi = 3;
    g_dat[1]  = 256'hA1;
    g_left[1] = 1;
    run(8);
    check("t2_beats", dat_log.size(), 3);
    check("t2_d0", dat_log[0], 256'hA1);
    check("t2_d1", dat_log[1], 256'hA2);
    check("t2_d2", dat_log[2], 256'hA3);
    check("t2_last", {last_log[0], last_log[1], last_log[2]}, 3'b001);
    check("t2_gid", grant_id, 1);
    check("t2_cnt1", pkt_count[63:32], 1);

    // Both sources offer 2-beat packets back to back.
    pulse_rst();
    clear_logs();
    g_lo = 2; g_hi = 2;
    g_dat[0] = 256'h100; g_dat[1] = 256'h200;
    g_left[0] = 2; g_left[1] = 2;
    run(16);
    check("t3_ngnt", gnt_log.size(), 4);
    for (int k = 0; k < 4; k++) check("t3_gnt", gnt_log[k], k % 2);
    exp_seq = '{256'h100, 256'h101, 256'h200, 256'h201,
                256'h102, 256'h103, 256'h202, 256'h203};
    for (int k = 0; k < 8; k++) check("t3_order", dat_log[k], exp_seq[k]);
    check("t3_cnt0", pkt_count[31:0], 2);
    check("t3_cnt1", pkt_count[63:32], 2);

    // Source 0 with toggling ready and a 2-cycle tvalid gap.
    pulse_rst();
    clear_logs();
    rdy_mode = 1;
    g_lo = 5; g_hi = 5;
    g_left[0] = 1;
    for (int c = 0; c < 30; c++) begin
      drive();
      if (c == 3 || c == 4) bus.s_tvalid[0] = 1'b0;
      step();
    end
    rdy_mode = 0;
    check("t4_cnt0", pkt_count[31:0], 1);
    check("t4_ngnt", gnt_log.size(), 1);

    // Source 0 disabled while both offer packets.
    pulse_rst();
    clear_logs();
    src_enable = 2'b10;
    g_lo = 2; g_hi = 2;
    g_left[0] = 3; g_left[1] = 3;
    run(20);
    check("t5_ngnt", gnt_log.size(), 3);
    for (int k = 0; k < 3; k++) check("t5_gnt", gnt_log[k], 1);
    check("t5_cnt0", pkt_count[31:0], 0);
    src_enable = '1;
    run(20);

    // Reset on beat 2 of a 4-beat packet from source 1.
    pulse_rst();
    clear_logs();
    g_lo = 4; g_hi = 4;
    g_left[0] = 0; g_left[1] = 1;
    run(2);
    pulse_rst();
    check("t6_busy", busy, 0);
    check("t6_valid", bus.m_tvalid, 0);
    check("t6_cnt", pkt_count, '0);
    clear_logs();
    g_left[0] = 1; g_left[1] = 1;
    run(14);
    check("t6_first", gnt_log[0], 0);

    // Counter wrap from 0xFFFFFFFF.
    pulse_rst();
    g_lo = 1; g_hi = 1;
    pk = pkt_count;
    pk[31:0] = '1;
    force dut.r_pkt_count = pk;
    #1;
    release dut.r_pkt_count;
    md_cnt[0] = 32'hFFFF_FFFF;
    g_left[0] = 1;
    run(6);
    check("t7_wrap", pkt_count[31:0], 0);

    // Randomized traffic, enables and occasional reset.
    pulse_rst();
    g_lo = 1; g_hi = 4; g_vpct = 70; rdy_pct = 70;
    for (int i = 0; i < NUM_SRC; i++) g_left[i] = 1000;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(63, 0) == 0) src_enable = NUM_SRC'($urandom);
      rst = ($urandom_range(499, 0) == 0);
      drive();
      step();
    end
    rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/tx_stream_arbiter.md
Name: tx_stream_arbiter

Overview:
- Packet-granular round-robin arbiter that shares the single 256-bit AXI-stream TX datapath between NUM_SRC requesters, e.g. host DMA and on-chip responders.
- Sits directly upstream of the TX MAC interface and of the TX packet counter.
- A grant is held for a whole packet, so beats from different sources never interleave.
- Keeps per-source packet counts for software visibility.

Parameters:
NUM_SRC, 2, number of requesting sources (2..8)
DATA_W, 256, tdata width per source and on the output
SRC_W, 3, width of grant_id; must satisfy 2**SRC_W >= NUM_SRC

Ports:
clk  in  1  single clock for all logic
rst  in  1  synchronous, active-high reset
src_enable  in  NUM_SRC  per-source enable; a disabled source is never granted
s_tdata  in  NUM_SRC*DATA_W  source data, source i at bits [i*DATA_W +: DATA_W]
s_tvalid  in  NUM_SRC  per-source valid
s_tlast  in  NUM_SRC  per-source last beat of packet
s_tready  out  NUM_SRC  per-source ready; only the granted bit can be 1
m_tdata  out  DATA_W  arbitrated output data
m_tvalid  out  1  output valid
m_tlast  out  1  output last
m_tready  in  1  downstream ready
busy  out  1  1 while a packet grant is held
grant_id  out  SRC_W  index of the current or most recent grant
pkt_count  out  NUM_SRC*32  per-source count of completed packets, source i at [i*32 +: 32]

Behaviour:
- Reset values, all synchronous to clk with rst=1:
  - state=IDLE, busy=0, grant_id=0.
  - last_grant=NUM_SRC-1, so source 0 has first priority.
  - All pkt_count fields=0.
  - m_tvalid=0, m_tlast=0, s_tready=0, m_tdata=0.
- States: IDLE and BUSY.
- IDLE:
  - req = s_tvalid & src_enable.
  - If req is nonzero, select the first set bit scanning last_grant+1, last_grant+2, ... modulo NUM_SRC.
  - Register the selection into grant_id, set busy=1, and move to BUSY on the next edge.
  - If req is zero, stay in IDLE.
  - Outputs in IDLE: m_tvalid=0, s_tready all 0.
  - Arbitration costs exactly one bubble cycle per packet.
- BUSY, with g = grant_id (combinational pass-through, zero latency):
  - m_tdata = s_tdata[g], m_tvalid = s_tvalid[g], m_tlast = s_tlast[g].
  - s_tready[g] = m_tready; every other s_tready bit = 0.
- A beat transfers when m_tvalid && m_tready. On a transfer with m_tlast=1:
  - pkt_count[g] increments by 1 (32-bit, wraps from 0xFFFFFFFF to 0).
  - last_grant <= g, busy <= 0, next state = IDLE.
  - grant_id keeps its value until the next grant.
- The grant is held through any number of beats and any tvalid gaps from the granted source.
- Deassertion of src_enable[g] mid-packet has no effect until the packet ends.
- Other sources' tvalid is ignored while BUSY; no preemption.
- Single-beat packet (tvalid and tlast on the first beat): the IDLE->BUSY->IDLE sequence holds normally; throughput is at most one packet per 2 cycles.
- Source requests in the same IDLE cycle as the tlast handshake are evaluated on the following IDLE cycle.
- rst asserted mid-packet: all state returns to reset values on that edge. The partial packet is abandoned; downstream is responsible for the truncated frame.
- m_tdata is don't-care when m_tvalid=0, but is driven 0 in IDLE.

Test Plan:
- Reset, then sources 0 and 1 idle, m_tready=1 -> m_tvalid=0, s_tready=2'b00, busy=0, pkt_count all 0.
- Source 1 only sends a 3-beat packet (data 0xA1,0xA2,0xA3), m_tready=1 -> one bubble after first tvalid; m_tdata sequence 0xA1,0xA2,0xA3; m_tlast on beat 3; grant_id=1; pkt_count[1]=1; busy drops the cycle after the last beat.
- Both sources continuously offer 2-beat packets -> grants alternate 0,1,0,1 starting with 0; after 4 packets pkt_count[0]=2 and pkt_count[1]=2; no beat interleaving.
- Granted source 0 with m_tready toggling 1,0,1,0 and a 2-cycle tvalid gap mid-packet -> s_tready[0] mirrors m_tready; s_tready[1]=0 throughout; grant held until the tlast handshake.
- src_enable=2'b10 with both sources valid -> only source 1 is granted; source 0 is stalled indefinitely with s_tready[0]=0.
- rst pulsed on beat 2 of a 4-beat packet -> next cycle busy=0, m_tvalid=0, pkt_count=0; a subsequent packet from source 0 is granted first.
- Preload: drive 2^32 single-beat packets, or force pkt_count[0]=0xFFFFFFFF, then send one packet -> pkt_count[0] wraps to 0.
